fetch_redirect: RTL and testbench

FETCH_REDIRECT -- requirements
Module: fetch_redirect

---
 rtl/fetch_redirect.sv | 76 +++++++
 tb/tb_fetch_redirect.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect.sv
// Fetch-stage PC generator with redirect/stall handling and pipeline flush control.
// A BOOT/RUN/KILL FSM sequences reset release, normal fetch and the redirect kill bubble.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_flag,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, KILL} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic        take;

  // Bit 0 of the target never matters; the fetch address is forced word-aligned.
  logic unused_redirect_bit;
  assign unused_redirect_bit = redirect_pc[0];

  assign pc4 = pc + 32'd4;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nx   = state;
    pc_nx      = pc;
    take       = 1'b0;
    if_valid   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN, KILL: begin
        flush_ifid = redirect_flag || (state == KILL);
        flush_idex = redirect_flag;
        if_valid   = (state == RUN) && !redirect_flag;
        if (redirect_flag) begin
          take     = 1'b1;
          pc_nx    = {redirect_pc[31:2], 2'b00};
          state_nx = KILL;
        end else begin
          state_nx = RUN;
          if (!stall) pc_nx = pc4;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misalign     <= 1'b0;
      redirect_cnt <= 16'h0000;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (take) begin
        if (redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
        if (redirect_pc[1]) misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Self-checking bench for fetch_redirect: a cycle model feeds a scoreboard queue,
// plus directed literal checks of the documented scenarios.
module tb_fetch_redirect;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int S_BOOT = 0, S_RUN = 1, S_KILL = 2;

  logic        clk = 1'b0;
  logic        rst, redirect_flag, stall;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc4;
  logic        if_valid, flush_ifid, flush_idex, misalign;
  logic [15:0] redirect_cnt;

  fetch_redirect #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_flag(redirect_flag), .redirect_pc(redirect_pc),
    .stall(stall), .pc(pc), .pc4(pc4), .if_valid(if_valid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        if_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;

  int          m_state;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, push the model's expectation,
  // compare the settled outputs, then advance the model to the next edge.
  task automatic step(input logic r, input logic rf, input logic [31:0] rpc, input logic st);
    exp_t e, o;
    @(negedge clk);
    rst = r; redirect_flag = rf; redirect_pc = rpc; stall = st;
    e.pc         = m_pc;
    e.pc4        = m_pc + 32'd4;
    e.if_valid   = (m_state == S_RUN) && !rf;
    e.flush_idex = (m_state != S_BOOT) && rf;
    e.flush_ifid = (m_state != S_BOOT) && (rf || m_state == S_KILL);
    e.misalign   = m_mis;
    e.cnt        = m_cnt;
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check("sb_pc", pc, o.pc);
    check("sb_pc4", pc4, o.pc4);
    check("sb_if_valid", {31'd0, if_valid}, {31'd0, o.if_valid});
    check("sb_flush_ifid", {31'd0, flush_ifid}, {31'd0, o.flush_ifid});
    check("sb_flush_idex", {31'd0, flush_idex}, {31'd0, o.flush_idex});
    check("sb_misalign", {31'd0, misalign}, {31'd0, o.misalign});
    check("sb_cnt", {16'd0, redirect_cnt}, {16'd0, o.cnt});
    if (r) begin
      m_state = S_BOOT; m_pc = RESET_PC; m_mis = 1'b0; m_cnt = 16'd0;
    end else if (m_state == S_BOOT) begin
      m_state = S_RUN;
    end else if (rf) begin
      m_pc = {rpc[31:2], 2'b00};
      if (rpc[1]) m_mis = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_state = S_KILL;
    end else begin
      if (!st) m_pc = m_pc + 32'd4;
      m_state = S_RUN;
    end
  endtask

  initial begin
    rst = 1'b1; redirect_flag = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    @(posedge clk);
    m_state = S_BOOT; m_pc = RESET_PC; m_mis = 1'b0; m_cnt = 16'd0;
    step(1, 0, 0, 0);

    // Reset release: pc 0,0,4,8 and if_valid 0,1,1,1; BOOT ignores redirect and stall.
    step(0, 1, 32'h0000_0500, 1);
    check("boot_pc", pc, 32'h0);
    check("boot_if_valid", {31'd0, if_valid}, 32'd0);
    check("boot_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    step(0, 0, 0, 0); check("run1_pc", pc, 32'h0); check("run1_iv", {31'd0, if_valid}, 32'd1);
    step(0, 0, 0, 0); check("run2_pc", pc, 32'h4);
    step(0, 0, 0, 0); check("run3_pc", pc, 32'h8);
    step(0, 0, 0, 0);

    // Redirect at pc=0x10 to a misaligned target.
    step(0, 1, 32'h0000_0102, 0);
    check("r034_pc", pc, 32'h10);
    check("r034_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    check("r034_flush_idex", {31'd0, flush_idex}, 32'd1);
    step(0, 0, 0, 0);
    check("r034_next_pc", pc, 32'h100);
    check("r034_next_iv", {31'd0, if_valid}, 32'd0);
    check("r034_misalign", {31'd0, misalign}, 32'd1);
    check("r034_cnt", {16'd0, redirect_cnt}, 32'd1);
    step(0, 0, 0, 0); check("r034_follow_pc", pc, 32'h104);

    // Stall alone holds; redirect beats a simultaneous stall.
    step(0, 1, 32'h0000_001C, 0);
    step(0, 0, 0, 0); check("r035_kill_pc", pc, 32'h1C);
    step(0, 0, 0, 1); check("r035_stall_pc", pc, 32'h20); check("r035_stall_iv", {31'd0, if_valid}, 32'd1);
    step(0, 1, 32'h0000_0200, 1); check("r035_hold_pc", pc, 32'h20);
    step(0, 0, 0, 0); check("r035_redir_pc", pc, 32'h200);

    // Back-to-back redirects keep KILL for two cycles.
    step(0, 1, 32'h0000_0040, 0);
    step(0, 1, 32'h0000_0080, 0); check("r036_pc40", pc, 32'h40);
    step(0, 0, 0, 0);
    check("r036_pc80", pc, 32'h80);
    check("r036_kill_flush", {31'd0, flush_ifid}, 32'd1);
    check("r036_kill_iv", {31'd0, if_valid}, 32'd0);
    step(0, 0, 0, 0); check("r036_pc84", pc, 32'h84); check("r036_cnt", {16'd0, redirect_cnt}, 32'd5);

    // Stall inside KILL holds pc.
    step(0, 1, 32'h0000_0600, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0); check("kill_stall_pc", pc, 32'h600);

    // Reset during KILL with a pending redirect.
    step(0, 1, 32'h0000_0300, 0);
    step(1, 1, 32'h0000_0402, 0);
    step(0, 0, 0, 0);
    check("r038_pc", pc, RESET_PC);
    check("r038_cnt", {16'd0, redirect_cnt}, 32'd0);
    check("r038_mis", {31'd0, misalign}, 32'd0);
    check("r038_boot_iv", {31'd0, if_valid}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 2) == 0));

    // Saturation of redirect_cnt and pc wrap.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 1, {$urandom} & 32'hFFFF_FFF0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0); check("r037_cnt_full", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    step(0, 0, 0, 0);
    check("r037_cnt_sat", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    check("r037_pc_top", pc, 32'hFFFF_FFFC);
    check("r037_pc4_wrap", pc4, 32'h0);
    step(0, 0, 0, 0); check("r037_pc_wrap", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
